// File: rtl/window_streamer_pkg.sv
// window_pkg: types and helpers shared by window_streamer and frame_buffer.
//   pixel_t  - one 8-bit pixel
//   state_t  - window_streamer controller states
//   width_of - $clog2 clamped to at least one bit, for port/index widths
package window_pkg;

    typedef logic [7:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        EMIT,
        FINISH
    } state_t;

    function automatic int width_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/window_streamer_frame_buffer.sv
// frame_buffer: IMG_DIM x IMG_DIM pixel store for window_streamer.
// Ports:
//   clk        - write clock (rising edge)
//   wr_en_i    - write one memory word at (wr_row_i, wr_wcol_i)
//   wr_row_i   - frame row of the word
//   wr_wcol_i  - word column; pixel column = wr_wcol_i*WORD_BYTES + k
//   wr_data_i  - word; the most significant byte is the lowest pixel column
//   win_row_i  - top-left row of the read window
//   win_col_i  - top-left column of the read window
//   win_data_o - WIN_DIM x WIN_DIM window, pixel [i][j] at bits (i*WIN_DIM+j)*8 +: 8
// The store has no reset; its contents are only meaningful after a full fill.
module frame_buffer
    import window_pkg::*;
#(
    parameter int IMG_DIM    = 80,
    parameter int WIN_DIM    = 16,
    parameter int WORD_BYTES = 4,
    localparam int RW = width_of(IMG_DIM),
    localparam int WW = width_of(IMG_DIM / WORD_BYTES)
) (
    input  logic                         clk,
    input  logic                         wr_en_i,
    input  logic [RW-1:0]                wr_row_i,
    input  logic [WW-1:0]                wr_wcol_i,
    input  logic [8*WORD_BYTES-1:0]      wr_data_i,
    input  logic [RW-1:0]                win_row_i,
    input  logic [RW-1:0]                win_col_i,
    output logic [WIN_DIM*WIN_DIM*8-1:0] win_data_o
);

    pixel_t mem [IMG_DIM][IMG_DIM];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                mem[wr_row_i][RW'(int'(wr_wcol_i) * WORD_BYTES + k)] <=
                    wr_data_i[8*(WORD_BYTES-k)-1 -: 8];
            end
        end
    end

    for (genvar i = 0; i < WIN_DIM; i++) begin : g_row
        for (genvar j = 0; j < WIN_DIM; j++) begin : g_col
            assign win_data_o[(i*WIN_DIM+j)*8 +: 8] = mem[win_row_i + RW'(i)][win_col_i + RW'(j)];
        end
    end

endmodule

// File: rtl/window_streamer.sv
// window_streamer: loads a square frame word by word from memory, then streams
// every WIN_DIM x WIN_DIM window (step STRIDE in both axes) over a
// valid/ready handshake.
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start / start_ack   - frame load request / one-cycle acceptance pulse
//   rd_req, rd_row,
//   rd_wcol             - single outstanding word read, row-major order
//   rd_valid, rd_data   - read response (MSB byte = lowest pixel column)
//   win_data            - window, pixel [i][j] at bits (i*WIN_DIM+j)*8 +: 8
//   win_valid/win_ready - window handshake
//   win_row, win_col    - top-left pixel of the presented window
//   busy, done          - load/stream in progress, end-of-frame pulse
//   win_sum             - sum of all window pixels (only with WINSTREAM_SUM_EN)
// Build option: define WINSTREAM_SUM_EN to add the win_sum output.
//
// state  | meaning
// IDLE   | waiting for start
// FILL   | reading the frame into the buffer, one word in flight at most
// EMIT   | presenting windows, advancing on each handshake
// FINISH | done pulse, back to IDLE next cycle
module window_streamer
    import window_pkg::*;
#(
    parameter int IMG_DIM    = 80,
    parameter int WIN_DIM    = 16,
    parameter int WORD_BYTES = 4,
    parameter int STRIDE     = 1,
    localparam int RW = width_of(IMG_DIM),
    localparam int WW = width_of(IMG_DIM / WORD_BYTES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         start_ack,
    output logic                         rd_req,
    output logic [RW-1:0]                rd_row,
    output logic [WW-1:0]                rd_wcol,
    input  logic                         rd_valid,
    input  logic [8*WORD_BYTES-1:0]      rd_data,
    output logic [WIN_DIM*WIN_DIM*8-1:0] win_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [RW-1:0]                win_row,
    output logic [RW-1:0]                win_col,
    output logic                         busy,
    output logic                         done
`ifdef WINSTREAM_SUM_EN
    ,
    output logic [width_of(WIN_DIM*WIN_DIM*255+1)-1:0] win_sum
`endif
);

    localparam int LAST_WCOL = IMG_DIM / WORD_BYTES - 1;
    localparam int LAST_POS  = IMG_DIM - WIN_DIM;

    if (IMG_DIM % WORD_BYTES != 0) begin : g_bad_word
        $fatal(1, "window_streamer: IMG_DIM must be a multiple of WORD_BYTES");
    end
    if (WIN_DIM > IMG_DIM) begin : g_bad_win
        $fatal(1, "window_streamer: WIN_DIM must not exceed IMG_DIM");
    end
    if (STRIDE < 1) begin : g_bad_stride
        $fatal(1, "window_streamer: STRIDE must be at least 1");
    end else if ((IMG_DIM - WIN_DIM) % STRIDE != 0) begin : g_bad_step
        $fatal(1, "window_streamer: STRIDE must divide IMG_DIM-WIN_DIM");
    end

    state_t state_q;
    logic   wr_en;

    // A response only counts while our request is outstanding.
    assign wr_en = (state_q == FILL) && rd_req && rd_valid;

    frame_buffer #(
        .IMG_DIM    (IMG_DIM),
        .WIN_DIM    (WIN_DIM),
        .WORD_BYTES (WORD_BYTES)
    ) u_frame_buffer (
        .clk        (clk),
        .wr_en_i    (wr_en),
        .wr_row_i   (rd_row),
        .wr_wcol_i  (rd_wcol),
        .wr_data_i  (rd_data),
        .win_row_i  (win_row),
        .win_col_i  (win_col),
        .win_data_o (win_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_ack <= 1'b0;
            rd_req    <= 1'b0;
            rd_row    <= '0;
            rd_wcol   <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_ack <= 1'b0;
            done      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        start_ack <= 1'b1;
                        busy      <= 1'b1;
                        rd_req    <= 1'b1;
                        rd_row    <= '0;
                        rd_wcol   <= '0;
                        state_q   <= FILL;
                    end
                end
                FILL: begin
                    if (rd_req) begin
                        if (rd_valid) begin
                            // Drop the request for a cycle; the next address goes out after.
                            rd_req <= 1'b0;
                            if (rd_wcol == WW'(LAST_WCOL)) begin
                                rd_wcol <= '0;
                                if (rd_row == RW'(IMG_DIM - 1)) begin
                                    rd_row    <= '0;
                                    win_row   <= '0;
                                    win_col   <= '0;
                                    win_valid <= 1'b1;
                                    state_q   <= EMIT;
                                end else begin
                                    rd_row <= rd_row + RW'(1);
                                end
                            end else begin
                                rd_wcol <= rd_wcol + WW'(1);
                            end
                        end
                    end else begin
                        rd_req <= 1'b1;
                    end
                end
                EMIT: begin
                    // win_valid is always high here, so win_ready alone completes the handshake.
                    if (win_ready) begin
                        if (win_col == RW'(LAST_POS)) begin
                            if (win_row == RW'(LAST_POS)) begin
                                win_valid <= 1'b0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                state_q   <= FINISH;
                            end else begin
                                win_col <= '0;
                                win_row <= win_row + RW'(STRIDE);
                            end
                        end else begin
                            win_col <= win_col + RW'(STRIDE);
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WINSTREAM_SUM_EN
    localparam int SUM_W = width_of(WIN_DIM*WIN_DIM*255+1);

    always_comb begin
        win_sum = '0;
        for (int p = 0; p < WIN_DIM*WIN_DIM; p++) begin
            win_sum = win_sum + SUM_W'(win_data[p*8 +: 8]);
        end
    end
`endif

endmodule

// File: doc/window_streamer.md
WINDOW_STREAMER -- requirements
Module: window_streamer

Interface
REQ-001 SHALL have parameter IMG_DIM, default 80: square frame edge in pixels.
REQ-002 SHALL have parameter WIN_DIM, default 16: square window edge in pixels.
REQ-003 SHALL have parameter WORD_BYTES, default 4: pixels per memory word (8-bit pixels).
REQ-004 SHALL have parameter STRIDE, default 1: window step in pixels, both axes.
REQ-005 SHALL have clk, input, 1: clock; all logic on the rising edge.
REQ-006 SHALL have rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have start, input, 1: request a new frame load.
REQ-008 SHALL have start_ack, output, 1: one-cycle pulse when start is accepted.
REQ-009 SHALL have rd_req, output, 1: memory read request.
REQ-010 SHALL have rd_row, output, clog2(IMG_DIM): frame row of the requested word.
REQ-011 SHALL have rd_wcol, output, clog2(IMG_DIM/WORD_BYTES): word column of the requested word.
REQ-012 SHALL have rd_valid, input, 1: rd_data holds the response to the outstanding request.
REQ-013 SHALL have rd_data, input, 8*WORD_BYTES: read word; bits [8*WORD_BYTES-1 -: 8] are the lowest pixel column.
REQ-014 SHALL have win_data, output, WIN_DIM x WIN_DIM x 8: current window, [i][j] = frame[win_row+i][win_col+j].
REQ-015 SHALL have win_valid, output, 1, and win_ready, input, 1: window handshake.
REQ-016 SHALL have win_row and win_col, outputs, clog2(IMG_DIM) each: top-left pixel of the current window.
REQ-017 SHALL have busy, output, 1: high from start acceptance until done; done, output, 1: one-cycle pulse after the last window.

Function
REQ-018 SHALL implement states IDLE, FILL, EMIT, FINISH.
REQ-019 SHALL, in IDLE with start=1, pulse start_ack, assert busy, and enter FILL the next cycle.
REQ-020 SHALL, in FILL, keep at most one request outstanding; rd_req stays high with stable rd_row/rd_wcol until rd_valid.
REQ-021 SHALL issue word addresses row-major, from (0,0) to (IMG_DIM-1, IMG_DIM/WORD_BYTES-1).
REQ-022 SHALL, on rd_valid, write the word into the frame buffer and present the next request no earlier than the following cycle.
REQ-023 SHALL ignore rd_valid when no request is outstanding.
REQ-024 SHALL enter EMIT after the last word is written, with win_row=win_col=0.
REQ-025 SHALL hold win_valid high in EMIT, keeping win_data/win_row/win_col stable until win_valid and win_ready are both high.
REQ-026 SHALL, on handshake, advance win_col by STRIDE, or at win_col=IMG_DIM-WIN_DIM wrap win_col to 0 and add STRIDE to win_row.
REQ-027 SHALL enter FINISH on the handshake at (IMG_DIM-WIN_DIM, IMG_DIM-WIN_DIM), pulse done, drop busy, and return to IDLE next cycle.
REQ-028 SHALL ignore start in any state other than IDLE.
REQ-029 SHALL accept back-to-back windows: one window per cycle while win_ready stays high.
REQ-030 SHALL check at elaboration that IMG_DIM%WORD_BYTES==0, WIN_DIM<=IMG_DIM, STRIDE>=1, and (IMG_DIM-WIN_DIM)%STRIDE==0; any violation is a fatal error.

Reset
REQ-031 SHALL, on rst_n low at any time (including mid-FILL or mid-EMIT), enter IDLE and hold start_ack, rd_req, win_valid, busy and done at 0, and rd_row, rd_wcol, win_row and win_col at 0.
REQ-032 SHALL NOT require the frame-buffer contents or win_data to be reset.

Configuration
REQ-033 SHALL, with WINSTREAM_SUM_EN defined, add output win_sum, width clog2(WIN_DIM*WIN_DIM*255+1): the sum of all win_data pixels, valid and stable whenever win_valid is high.
REQ-034 SHALL, without WINSTREAM_SUM_EN, omit win_sum and all summing logic.

Structure
REQ-035 SHALL place the pixel_t typedef (8-bit) and the state enum in shared package window_pkg.
REQ-036 SHALL implement storage as sub-module frame_buffer: IMG_DIM x IMG_DIM pixels, one word-wide write port, and a WIN_DIM x WIN_DIM read window at (win_row, win_col).

Verification
REQ-037 SHALL cover: defaults, frame[r][c]=(r+c)%256, rd_valid 1 cycle after rd_req, win_ready=1 -> 4225 windows; window (1,0) has [0][0]=1; done pulses once.
REQ-038 SHALL cover: rd_valid latency randomised 1-7 cycles -> exactly 1600 reads, no second request while one is outstanding, identical windows.
REQ-039 SHALL cover: STRIDE=4, WIN_DIM=16 -> 289 windows; last window at (64,64).
REQ-040 SHALL cover: win_ready low 5 cycles at window (0,3) -> win_valid, win_data and win_col=3 held stable; start pulsed mid-EMIT is ignored (no start_ack).
REQ-041 SHALL cover: rst_n asserted at word 700 of FILL -> all outputs at reset values; a fresh start completes normally.
REQ-042 SHALL cover: WINSTREAM_SUM_EN, all pixels 255, WIN_DIM=16 -> win_sum=65280 on every window.
